// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared stage indices, FSM encoding and stall mask helper
package pipe_hazard_ctrl_pkg;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam int STALL_W = STG_WB + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_e;

    // Holding stage k also holds everything upstream of it, so the mask is bits 0..k.
    function automatic logic [31:0] stage_mask(input int unsigned k);
        stage_mask = (32'd2 << k) - 32'd1;
    endfunction

endpackage

// File: rtl/hazard_mc_counter.sv
// rtl/hazard_mc_counter.sv - fixed-latency stall counter with load, decrement and busy
module hazard_mc_counter
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_len,
    input  logic          i_clear,
    output logic          o_busy
);

    logic [CW-1:0] r_count;

    // The load cycle itself is already stalled by the caller, so only len-1 remains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end else if (i_load && (i_len != '0)) begin
            r_count <= i_len - CW'(1);
        end
    end

    assign o_busy = (r_count != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall merge, exception flush sequencer and stall watchdog
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int                    NUM_STAGES   = STALL_W,
    parameter int                    NUM_REQ      = 2,
    parameter int                    SW           = 3,
    parameter logic [NUM_REQ*SW-1:0] REQ_STAGE    = {SW'(STG_WB), SW'(STG_ID)},
    parameter int                    MC_STAGE     = STG_WB,
    parameter int                    CW           = 6,
    parameter int                    FLUSH_CYCLES = 1,
    parameter int                    TIMEOUT      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    stall_req,
    input  logic                  mc_start,
    input  logic [CW-1:0]         mc_cycles,
    input  logic                  excp_req,
    input  logic [31:0]           excp_pc,
    output logic [NUM_STAGES-1:0] stall,
    output logic                  flush,
    output logic [31:0]           new_pc,
    output logic                  mc_busy,
    output logic                  stall_timeout
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [NUM_STAGES-1:0] MC_MASK = NUM_STAGES'(stage_mask(MC_STAGE));

    hz_state_e               r_state;
    hz_state_e               w_state_nxt;
    logic [FW-1:0]           r_fcnt;
    logic [FW-1:0]           w_fcnt_nxt;
    logic [31:0]             r_new_pc;
    logic [TW-1:0]           r_wd_cnt;
    logic [TW-1:0]           w_wd_nxt;
    logic                    r_timeout;
    logic                    w_flush;
    logic                    w_enter_flush;
    logic                    w_mc_fresh;
    logic [NUM_STAGES-1:0]   w_req_stall;

    assign w_flush       = (r_state == ST_FLUSH);
    assign w_enter_flush = (r_state == ST_IDLE) && excp_req;
    assign w_mc_fresh    = mc_start && (mc_cycles != '0) && !mc_busy;

    always_comb begin
        w_req_stall = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (stall_req[r]) begin
                w_req_stall = w_req_stall | NUM_STAGES'(stage_mask(32'(REQ_STAGE[r*SW +: SW])));
            end
        end
    end

    // Stall is suppressed while the pipe is being invalidated and while in reset.
    assign stall = (!rst || w_flush) ? '0
                 : (w_req_stall | ((mc_busy || w_mc_fresh) ? MC_MASK : '0));

    hazard_mc_counter #(
        .CW (CW)
    ) u_mc_counter (
        .clk     (clk),
        .rst_n   (rst),
        .i_load  (mc_start && !w_enter_flush),
        .i_len   (mc_cycles),
        .i_clear (w_enter_flush),
        .o_busy  (mc_busy)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            ST_IDLE: begin
                if (excp_req) begin
                    w_state_nxt = ST_FLUSH;
                    w_fcnt_nxt  = FW'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (r_fcnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_fcnt_nxt = r_fcnt - FW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_fcnt   <= '0;
            r_new_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            if (w_enter_flush) begin
                r_new_pc <= excp_pc;
            end
        end
    end

    assign w_wd_nxt = (stall == '0)               ? '0
                    : (r_wd_cnt == TW'(TIMEOUT)) ? r_wd_cnt
                    :                              r_wd_cnt + TW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wd_cnt  <= w_wd_nxt;
            r_timeout <= r_timeout | (w_wd_nxt == TW'(TIMEOUT));
        end
    end

    assign flush         = w_flush;
    assign new_pc        = r_new_pc;
    assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int NS = 6;
    localparam int FC = 1;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  stall_req;
    logic        mc_start;
    logic [5:0]  mc_cycles;
    logic        excp_req;
    logic [31:0] excp_pc;
    logic [NS-1:0] stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy;
    logic        stall_timeout;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req     (stall_req),
        .mc_start      (mc_start),
        .mc_cycles     (mc_cycles),
        .excp_req      (excp_req),
        .excp_pc       (excp_pc),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .mc_busy       (mc_busy),
        .stall_timeout (stall_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: absolute cycle windows instead of counters.
    int          req_stage [2] = '{2, 5};
    int          t;
    int          mc_s, mc_end;
    int          fl_s, fl_e;
    int          consec;
    logic [31:0] m_pc;
    bit          m_to;

    function automatic logic [5:0] mask_of(input int k);
        int v;
        v = (1 << (k + 1)) - 1;
        return 6'(v);
    endfunction

    task automatic model_reset();
        t      = 0;
        mc_s   = -100;
        mc_end = -100;
        fl_s   = -100;
        fl_e   = -100;
        consec = 0;
        m_pc   = '0;
        m_to   = 1'b0;
    endtask

    task automatic step(input logic [1:0] req, input logic ms, input logic [5:0] mc,
                        input logic ex, input logic [31:0] pc);
        bit         in_fl;
        bit         busy;
        bit         fresh;
        logic [5:0] es;
        stall_req = req;
        mc_start  = ms;
        mc_cycles = mc;
        excp_req  = ex;
        excp_pc   = pc;
        in_fl = (t >= fl_s) && (t < fl_e);
        busy  = (t > mc_s) && (t < mc_end);
        fresh = ms && (mc != 0) && !busy;
        es = '0;
        for (int r = 0; r < 2; r++) if (req[r]) es |= mask_of(req_stage[r]);
        if (busy || fresh) es |= mask_of(5);
        if (in_fl) es = '0;
        @(negedge clk);
        check_eq("stall",   32'(stall),         32'(es));
        check_eq("flush",   32'(flush),         32'(in_fl));
        check_eq("new_pc",  new_pc,             m_pc);
        check_eq("mc_busy", 32'(mc_busy),       32'(busy));
        check_eq("timeout", 32'(stall_timeout), 32'(m_to));
        @(posedge clk);
        if (!in_fl && ex) begin
            fl_s   = t + 1;
            fl_e   = t + 1 + FC;
            m_pc   = pc;
            mc_end = t + 1;
        end else if (fresh) begin
            mc_s   = t;
            mc_end = t + int'(mc);
        end
        if (es != 0) begin
            if (consec < TO) consec++;
        end else begin
            consec = 0;
        end
        if (consec >= TO) m_to = 1'b1;
        t++;
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            stall_req = 2'($urandom);
            mc_start  = 1'($urandom);
            mc_cycles = 6'($urandom);
            excp_req  = 1'($urandom);
            excp_pc   = $urandom;
            @(negedge clk);
            check_eq("rst_stall",   32'(stall),         32'h0);
            check_eq("rst_flush",   32'(flush),         32'h0);
            check_eq("rst_new_pc",  new_pc,             32'h0);
            check_eq("rst_mc_busy", 32'(mc_busy),       32'h0);
            check_eq("rst_timeout", 32'(stall_timeout), 32'h0);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 1'b0, 6'd0, 1'b0, 32'h0);
    endtask

    initial begin
        rst       = 1'b0;
        stall_req = '0;
        mc_start  = 1'b0;
        mc_cycles = '0;
        excp_req  = 1'b0;
        excp_pc   = '0;
        model_reset();
        do_reset(4);

        step(2'b01, 1'b0, 6'd0, 1'b0, 32'h0);
        check_eq("merge01_lit", 32'(stall), 32'h07);
        step(2'b11, 1'b0, 6'd0, 1'b0, 32'h0);
        check_eq("merge11_lit", 32'(stall), 32'h3f);
        step(2'b10, 1'b0, 6'd0, 1'b0, 32'h0);
        step(2'b00, 1'b0, 6'd0, 1'b0, 32'h0);
        check_eq("merge00_lit", 32'(stall), 32'h00);

        do_reset(1);
        step(2'b00, 1'b1, 6'd4, 1'b0, 32'h0);
        step(2'b00, 1'b0, 6'd0, 1'b0, 32'h0);
        step(2'b00, 1'b1, 6'd9, 1'b0, 32'h0);
        idle(5);
        step(2'b00, 1'b1, 6'd0, 1'b0, 32'h0);

        step(2'b00, 1'b1, 6'd10, 1'b0, 32'h0);
        idle(2);
        step(2'b01, 1'b0, 6'd0, 1'b1, 32'hBFC0_0380);
        check_eq("excp_flush_lit", 32'(flush), 32'h1);
        check_eq("excp_pc_lit",    new_pc,     32'hBFC0_0380);
        step(2'b11, 1'b0, 6'd0, 1'b1, 32'h1234_5678);
        idle(3);

        step(2'b00, 1'b1, 6'd5, 1'b1, 32'h8000_0180);
        idle(6);

        do_reset(1);
        for (int i = 0; i < 7; i++) step(2'b01, 1'b0, 6'd0, 1'b0, 32'h0);
        idle(3);
        check_eq("wd7_lit", 32'(stall_timeout), 32'h0);
        for (int i = 0; i < 8; i++) step(2'b01, 1'b0, 6'd0, 1'b0, 32'h0);
        idle(3);
        check_eq("wd8_lit", 32'(stall_timeout), 32'h1);

        step(2'b00, 1'b1, 6'd20, 1'b0, 32'h0);
        idle(2);
        do_reset(2);
        idle(2);
        step(2'b00, 1'b0, 6'd0, 1'b1, 32'hDEAD_BEEF);
        do_reset(1);
        idle(2);

        for (int i = 0; i < 600; i++) begin
            logic [1:0]  rq;
            logic        ms;
            logic [5:0]  mc;
            logic        ex;
            if ($urandom_range(0, 99) == 0) do_reset(1);
            rq = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            ms = ($urandom_range(0, 5) == 0);
            mc = 6'($urandom_range(0, 10));
            ex = ($urandom_range(0, 14) == 0);
            step(rq, ms, mc, ex, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
